dongwon_cache_ctrl: RTL and testbench

Miss/refill controller between the CPU fetch/load port and the `dongwon_cache` / `dongwon_ram` pair. It accepts one word request at a time and performs a cache lookup. On a hit it returns cache data. On a miss it reads `dongwon_ram`, fills the direct-mapped cache, then returns the word. Writes are write-through: RAM and cache are updated in the same cycle.

---
 rtl/dongwon_pkg.sv | 33 +++
 rtl/dongwon_sat_counter.sv | 34 +++
 rtl/dongwon_cache_ctrl.sv | 139 +++++++++++++
 tb/tb_dongwon_cache_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dongwon_pkg.sv
// Shared constants for the dongwon cache/RAM subsystem.
// Controller FSM encodings, width defaults, RAM latency bounds, cache codes.
package dongwon_pkg;

    localparam int DW_ADDR_WIDTH = 32;
    localparam int DW_DATA_WIDTH = 32;

    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 15;
    localparam int LAT_W       = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_RAM_RD = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_FILL   = 3'd5;
    localparam logic [2:0] ST_WRITE  = 3'd6;
    localparam logic [2:0] ST_RESP   = 3'd7;

    // Internal state codes of dongwon_cache, kept here so both sides agree.
    localparam logic [2:0] CACHE_IDLE      = 3'b000;
    localparam logic [2:0] CACHE_WRITE     = 3'b010;
    localparam logic [2:0] CACHE_READ_MISS = 3'b100;
    localparam logic [2:0] CACHE_READ_HIT  = 3'b101;

    function automatic logic [LAT_W-1:0] lat_clamp(input int lat);
        if (lat < RAM_LAT_MIN) return LAT_W'(RAM_LAT_MIN);
        if (lat > RAM_LAT_MAX) return LAT_W'(RAM_LAT_MAX);
        return LAT_W'(lat);
    endfunction

endpackage

// File: rtl/dongwon_sat_counter.sv
// Saturating up-counter used for the optional hit/miss statistics.
// Holds at all-ones instead of wrapping.
module dongwon_sat_counter
    import dongwon_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dongwon_cache_ctrl.sv
// Miss/refill controller: CPU word port to dongwon_cache + dongwon_ram.
// Define DONGWON_CACHE_CTRL_STATS_EN to add hit_cnt/miss_cnt outputs.
module dongwon_cache_ctrl
    import dongwon_pkg::*;
#(
    parameter int ADDR_WIDTH  = DW_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DW_DATA_WIDTH,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  c_run,
    output logic                  c_we,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic [DATA_WIDTH-1:0] c_in_data,
    input  logic                  c_hit,
    input  logic [DATA_WIDTH-1:0] c_out_data,
    output logic                  r_run,
    output logic                  r_we,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_in_data,
    input  logic [DATA_WIDTH-1:0] r_out_data
`ifdef DONGWON_CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam logic [LAT_W-1:0] LAT = lat_clamp(RAM_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK =
        {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr & WORD_MASK;
                    data_d  = cpu_wdata;
                    state_d = cpu_we ? ST_WRITE : ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_d = ST_CHECK;
            ST_CHECK: begin
                if (c_hit) begin
                    data_d  = c_out_data;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_RAM_RD;
                end
            end
            ST_RAM_RD: begin
                cnt_d   = LAT;
                state_d = ST_WAIT;
            end
            // Counter reaching 1 marks the cycle r_out_data is valid.
            ST_WAIT: begin
                if (cnt_q <= LAT_W'(1)) begin
                    data_d  = r_out_data;
                    state_d = ST_FILL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FILL:  state_d = ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cpu_ready  = (state_q == ST_IDLE);
    assign cpu_rvalid = (state_q == ST_RESP);
    assign cpu_rdata  = data_q;

    assign c_run = (state_q == ST_LOOKUP) || (state_q == ST_FILL)
                || (state_q == ST_WRITE);
    assign c_we  = (state_q == ST_FILL) || (state_q == ST_WRITE);
    assign r_run = (state_q == ST_RAM_RD) || (state_q == ST_WRITE);
    assign r_we  = (state_q == ST_WRITE);

    assign c_addr    = addr_q;
    assign r_addr    = addr_q;
    assign c_in_data = data_q;
    assign r_in_data = data_q;

`ifdef DONGWON_CACHE_CTRL_STATS_EN
    logic hit_inc;
    logic miss_inc;

    assign hit_inc  = (state_q == ST_CHECK) && c_hit;
    assign miss_inc = (state_q == ST_CHECK) && !c_hit;

    dongwon_sat_counter #(.WIDTH(32)) u_hit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (hit_inc),
        .cnt     (hit_cnt)
    );

    dongwon_sat_counter #(.WIDTH(32)) u_miss_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (miss_inc),
        .cnt     (miss_cnt)
    );
`endif

endmodule

// File: tb/tb_dongwon_cache_ctrl.sv
// Bench for dongwon_cache_ctrl: two instances (RAM latency 1 and 3)
// with cache/RAM models and a word-level reference memory.
module tb_dongwon_cache_ctrl;

    logic clk = 1'b0;
    logic reset_n;

    logic [1:0]       cpu_req, cpu_we, cpu_ready, cpu_rvalid;
    logic [1:0]       c_run, c_we, c_hit, r_run, r_we;
    logic [1:0][31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0][31:0] c_addr, c_in_data, c_out_data;
    logic [1:0][31:0] r_addr, r_in_data, r_out_data;
`ifdef DONGWON_CACHE_CTRL_STATS_EN
    logic [1:0][31:0] hit_cnt, miss_cnt;
`endif

    int LATS [2] = '{1, 3};
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dongwon_cache_ctrl #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .RAM_LATENCY (g == 0 ? 1 : 3)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .cpu_req    (cpu_req[g]),
            .cpu_we     (cpu_we[g]),
            .cpu_addr   (cpu_addr[g]),
            .cpu_wdata  (cpu_wdata[g]),
            .cpu_ready  (cpu_ready[g]),
            .cpu_rvalid (cpu_rvalid[g]),
            .cpu_rdata  (cpu_rdata[g]),
            .c_run      (c_run[g]),
            .c_we       (c_we[g]),
            .c_addr     (c_addr[g]),
            .c_in_data  (c_in_data[g]),
            .c_hit      (c_hit[g]),
            .c_out_data (c_out_data[g]),
            .r_run      (r_run[g]),
            .r_we       (r_we[g]),
            .r_addr     (r_addr[g]),
            .r_in_data  (r_in_data[g]),
            .r_out_data (r_out_data[g])
`ifdef DONGWON_CACHE_CTRL_STATS_EN
            ,
            .hit_cnt    (hit_cnt[g]),
            .miss_cnt   (miss_cnt[g])
`endif
        );
    end

    // ---------------- environment: cache and RAM models ----------------
    logic        cv   [2][64];
    logic [31:0] ctag [2][64];
    logic [31:0] cdat [2][64];
    bit [31:0]   ram  [bit [32:0]];
    bit [31:0]   pre  [bit [32:0]];
    int          pend_cnt  [2] = '{0, 0};
    logic [31:0] pend_addr [2];
    bit          flush_req = 1'b1;

    function automatic logic [31:0] init_val(int g, logic [31:0] a);
        return a ^ 32'h5A5A_0000 ^ (g != 0 ? 32'h0100_0000 : 32'h0);
    endfunction

    function automatic logic [31:0] ram_rd(int g, logic [31:0] a);
        bit [32:0] k;
        k = {g[0], a};
        if (ram.exists(k)) return ram[k];
        if (pre.exists(k)) return pre[k];
        return init_val(g, a);
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int n;
            logic [5:0] ci;
            ci = c_addr[g][7:2];
            if (flush_req) begin
                for (int i = 0; i < 64; i++) cv[g][i] = 1'b0;
            end
            if (c_run[g] && !c_we[g]) begin
                c_hit[g]      <= cv[g][ci] && (ctag[g][ci] == c_addr[g]);
                c_out_data[g] <= cv[g][ci] ? cdat[g][ci] : $urandom;
            end else begin
                c_hit[g]      <= 1'($urandom);
                c_out_data[g] <= $urandom;
            end
            if (c_run[g] && c_we[g]) begin
                cv[g][ci]   = 1'b1;
                ctag[g][ci] = c_addr[g];
                cdat[g][ci] = c_in_data[g];
            end
            n = pend_cnt[g];
            if (r_run[g] && r_we[g]) ram[{g[0], r_addr[g]}] = r_in_data[g];
            if (r_run[g] && !r_we[g]) begin
                pend_addr[g] = r_addr[g];
                n = LATS[g];
            end
            if (n == 1) r_out_data[g] <= ram_rd(g, pend_addr[g]);
            else        r_out_data[g] <= $urandom;
            pend_cnt[g] = (n > 0) ? n - 1 : 0;
        end
    end

    // ---------------- reference model ----------------
    bit [31:0]   ref_mem [bit [32:0]];
    bit          ref_v   [2][64];
    logic [31:0] ref_tag [2][64];

    function automatic logic [31:0] ref_rd(int g, logic [31:0] a);
        bit [32:0] k;
        k = {g[0], a};
        if (ref_mem.exists(k)) return ref_mem[k];
        return init_val(g, a);
    endfunction

    task automatic preload(input int g, input logic [31:0] a,
                           input logic [31:0] v);
        pre[{g[0], a}]     = v;
        ref_mem[{g[0], a}] = v;
    endtask

    task automatic flush_all();
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 64; i++) ref_v[g][i] = 1'b0;
    endtask

    // One CPU transaction with latency, data, strobe and address checks.
    task automatic do_txn(input int g, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        logic [31:0] a, exp_data, got;
        logic [5:0]  idx;
        bit          hit, addr_ok, data_ok;
        int          exp_lat, lat, rr, rw, cw, rcyc, wcyc;
        a        = addr & 32'hFFFF_FFFC;
        idx      = a[7:2];
        hit      = !we && ref_v[g][idx] && (ref_tag[g][idx] == a);
        exp_data = we ? wdata : ref_rd(g, a);
        exp_lat  = we ? 2 : (hit ? 3 : 5 + LATS[g]);
        lat = 0; rr = 0; rw = 0; cw = 0; rcyc = 0; wcyc = 0;
        addr_ok = 1'b1; data_ok = 1'b1; got = '0;
        @(negedge clk);
        for (int k = 0; k < 20 && !cpu_ready[g]; k++) @(negedge clk);
        n_chk++;
        if (cpu_ready[g] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready g%0d: got %b expected 1", g, cpu_ready[g]);
        end
        cpu_req[g]   = 1'b1;
        cpu_we[g]    = we;
        cpu_addr[g]  = addr;
        cpu_wdata[g] = wdata;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            cpu_req[g]   = 1'b0;
            cpu_addr[g]  = $urandom;
            cpu_wdata[g] = $urandom;
            if (r_run[g] && !r_we[g]) begin rr++; rcyc = cyc; end
            if (r_run[g] && r_we[g]) begin
                rw++; wcyc = cyc;
                if (r_in_data[g] !== exp_data) data_ok = 1'b0;
            end
            if (c_run[g] && c_we[g]) begin
                cw++;
                if (c_in_data[g] !== exp_data) data_ok = 1'b0;
            end
            if (c_run[g] && c_addr[g] !== a) addr_ok = 1'b0;
            if (r_run[g] && r_addr[g] !== a) addr_ok = 1'b0;
            if (cpu_rvalid[g]) begin
                lat = cyc;
                got = cpu_rdata[g];
                break;
            end
        end
        n_chk++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL latency g%0d a=%h: got %0d expected %0d",
                     g, a, lat, exp_lat);
        end
        n_chk++;
        if (got !== exp_data) begin
            n_fail++;
            $display("FAIL rdata g%0d a=%h: got %h expected %h",
                     g, a, got, exp_data);
        end
        n_chk++;
        if (rr != ((!we && !hit) ? 1 : 0) || rw != (we ? 1 : 0)
            || cw != ((we || !hit) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL strobes g%0d a=%h: got rd%0d wr%0d cw%0d expected rd%0d wr%0d cw%0d",
                     g, a, rr, rw, cw, (!we && !hit) ? 1 : 0, we ? 1 : 0,
                     (we || !hit) ? 1 : 0);
        end
        n_chk++;
        if (rcyc != ((!we && !hit) ? 3 : 0) || wcyc != (we ? 1 : 0)) begin
            n_fail++;
            $display("FAIL strobe_cycle g%0d a=%h: got rd@%0d wr@%0d expected rd@%0d wr@%0d",
                     g, a, rcyc, wcyc, (!we && !hit) ? 3 : 0, we ? 1 : 0);
        end
        n_chk++;
        if (!(addr_ok && data_ok)) begin
            n_fail++;
            $display("FAIL port_values g%0d a=%h: got addr_ok=%b data_ok=%b expected 1 1",
                     g, a, addr_ok, data_ok);
        end
        if (we) ref_mem[{g[0], a}] = wdata;
        if (we || !hit) begin
            ref_v[g][idx]   = 1'b1;
            ref_tag[g][idx] = a;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            n_chk++;
            if ({c_run[g], c_we[g], r_run[g], r_we[g], cpu_rvalid[g]} !== 5'b0) begin
                n_fail++;
                $display("FAIL %s_strobes g%0d: got %b expected 00000", tag, g,
                         {c_run[g], c_we[g], r_run[g], r_we[g], cpu_rvalid[g]});
            end
            n_chk++;
            if ((cpu_rdata[g] | c_addr[g] | r_addr[g] | c_in_data[g]
                 | r_in_data[g]) !== 32'h0) begin
                n_fail++;
                $display("FAIL %s_values g%0d: got rdata=%h c_addr=%h r_addr=%h expected 0",
                         tag, g, cpu_rdata[g], c_addr[g], r_addr[g]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset_held");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_zero("reset_release");
        for (int g = 0; g < 2; g++) begin
            n_chk++;
            if (cpu_ready[g] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready g%0d: got %b expected 1", g, cpu_ready[g]);
            end
        end
    endtask

    task automatic test_write();
        do_txn(0, 1'b1, 32'h10, 32'hA5A5_A5A5);
        do_txn(0, 1'b0, 32'h10, 32'h0);
    endtask

    task automatic test_read_miss_hit();
        preload(0, 32'h20, 32'd8);
        do_txn(0, 1'b0, 32'h20, 32'h0);
        do_txn(0, 1'b0, 32'h20, 32'h0);
    endtask

    task automatic test_latency3();
        preload(1, 32'h44, 32'hC0DE_0044);
        do_txn(1, 1'b0, 32'h44, 32'h0);
        do_txn(1, 1'b0, 32'h47, 32'h0);
    endtask

    task automatic test_boundary();
        do_txn(0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
        do_txn(0, 1'b0, 32'hFFFF_FFFE, 32'h0);
        do_txn(1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) do_txn(0, 1'b0, 32'h20, 32'h0);
        do_txn(0, 1'b1, 32'h24, 32'h0BAD_F00D);
        do_txn(0, 1'b0, 32'h24, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2)
              | 32'($urandom_range(0, 3));
            do_txn(int'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4),
                   a, $urandom);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        int bad;
        a = 32'h0000_5A40;
        preload(1, a, 32'h7777_1111);
        @(negedge clk);
        cpu_req[1]  = 1'b1;
        cpu_we[1]   = 1'b0;
        cpu_addr[1] = a;
        repeat (5) begin
            @(negedge clk);
            cpu_req[1] = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check_idle_zero("reset_mid");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (c_we[1] || r_run[1] || cpu_rvalid[1]) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d strobe cycles expected 0", bad);
        end
        do_txn(1, 1'b0, a, 32'h0);
    endtask

`ifdef DONGWON_CACHE_CTRL_STATS_EN
    task automatic test_stats();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        flush_all();
        n_chk++;
        if ((hit_cnt[0] | miss_cnt[0]) !== 32'h0) begin
            n_fail++;
            $display("FAIL stats_reset: got hit=%0d miss=%0d expected 0 0",
                     hit_cnt[0], miss_cnt[0]);
        end
        for (int i = 0; i < 32; i++) do_txn(0, 1'b0, 32'(i * 4), 32'h0);
        for (int i = 0; i < 32; i++) do_txn(0, 1'b0, 32'(i * 4), 32'h0);
        n_chk++;
        if (miss_cnt[0] !== 32'd32 || hit_cnt[0] !== 32'd32) begin
            n_fail++;
            $display("FAIL stats_counts: got hit=%0d miss=%0d expected 32 32",
                     hit_cnt[0], miss_cnt[0]);
        end
    endtask
`endif

    initial begin
        cpu_req   = '0;
        cpu_we    = '0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        test_reset();
        flush_all();
        test_write();
        test_read_miss_hit();
        test_latency3();
        test_boundary();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef DONGWON_CACHE_CTRL_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
